// File: rtl/branch_ctrl.sv
// ---------------------------------------------------------------------------
// branch_ctrl
//
// Branch sequencer for the ID stage. It owns the compare unit. It accepts a
// branch from decode and holds it while operand hazards clear, re-sampling
// the forwarded operands on every one of those cycles. It then drives the
// compare unit, registers the outcome and sends a one-cycle PC redirect to
// fetch. It also keeps saturating branch/taken counters for performance debug.
//
// Optional feature macro: BRANCH_CTRL_LIKELY_EN
//   When defined, this adds input id_br_likely. A not-taken likely branch
//   then raises bd_nullify in DONE. When undefined, bd_nullify is tied to 0.
//
// Parameters:
//   CNT_W           width of the br_cnt / taken_cnt statistics counters
//
// Ports:
//   clk             system clock, rising edge
//   reset           asynchronous active-high reset
//   id_br_valid     branch present in ID (only looked at in IDLE)
//   id_br_cond      condition code, passed straight through to cmp_ctrl
//   id_pc           PC of the branch
//   id_imm16        signed branch offset in words
//   id_rs_val       forwarded rs operand
//   id_rt_val       forwarded rt operand
//   id_br_likely    branch-likely flag (only with BRANCH_CTRL_LIKELY_EN)
//   hazard_stall    operands not yet forwardable
//   flush           abort any in-flight branch
//   cmp_result      outcome returned by the compare unit
//   cmp_srcA/B      registered compare operands
//   cmp_ctrl        registered compare condition
//   busy            sequencer not idle, so decode must hold
//   redirect_valid  one-cycle taken pulse
//   redirect_pc     branch target, held between redirects
//   bd_nullify      delay-slot kill pulse
//   br_cnt          branches resolved (saturating)
//   taken_cnt       branches taken (saturating)
// ---------------------------------------------------------------------------
module branch_ctrl #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             id_br_valid,
    input  logic [3:0]       id_br_cond,
    input  logic [31:0]      id_pc,
    input  logic [15:0]      id_imm16,
    input  logic [31:0]      id_rs_val,
    input  logic [31:0]      id_rt_val,
`ifdef BRANCH_CTRL_LIKELY_EN
    input  logic             id_br_likely,
`endif
    input  logic             hazard_stall,
    input  logic             flush,
    input  logic             cmp_result,
    output logic [31:0]      cmp_srcA,
    output logic [31:0]      cmp_srcB,
    output logic [3:0]       cmp_ctrl,
    output logic             busy,
    output logic             redirect_valid,
    output logic [31:0]      redirect_pc,
    output logic             bd_nullify,
    output logic [CNT_W-1:0] br_cnt,
    output logic [CNT_W-1:0] taken_cnt
);

    typedef enum logic [1:0] {IDLE, WAIT, EVAL, DONE} state_t;

    state_t      state;
    state_t      state_next;
    logic [31:0] pc_r;
    logic [15:0] imm_r;
    logic        taken_r;
    logic        taken_now;
    logic [31:0] target;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    // The target is pc + 4 + (sign-extended word offset * 4). It wraps mod 2^32.
    assign target = pc_r + 32'd4 + {{14{imm_r[15]}}, imm_r, 2'b00};
    assign busy   = (state != IDLE);

    // An unknown compare result must count as not taken. An if with an X
    // condition falls through to the default.
    always_comb begin
        taken_now = 1'b0;
        if (cmp_result) begin
            taken_now = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // flush overrides every other transition and always returns to IDLE.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (id_br_valid) state_next = hazard_stall ? WAIT : EVAL;
            WAIT:    if (!hazard_stall) state_next = EVAL;
            EVAL:    state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
        if (flush) begin
            state_next = IDLE;
        end
    end

`ifdef BRANCH_CTRL_LIKELY_EN
    logic likely_r;
    logic bd_null_r;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            likely_r  <= 1'b0;
            bd_null_r <= 1'b0;
        end else begin
            bd_null_r <= 1'b0;
            if (state == IDLE && id_br_valid && !flush) begin
                likely_r <= id_br_likely;
            end
            if (state == EVAL && !flush) begin
                bd_null_r <= likely_r & ~taken_now;
            end
        end
    end

    // A flush that arrives in DONE still kills the nullify pulse in that cycle.
    assign bd_nullify = bd_null_r & ~flush;
`else
    assign bd_nullify = 1'b0;
`endif

    // The operand registers are the compare-unit outputs themselves. They are
    // loaded on accept and re-loaded in every WAIT cycle. The final load
    // happens on the edge into EVAL, so they stay stable for all of EVAL.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_r           <= '0;
            imm_r          <= '0;
            taken_r        <= 1'b0;
            cmp_srcA       <= '0;
            cmp_srcB       <= '0;
            cmp_ctrl       <= '0;
            redirect_valid <= 1'b0;
            redirect_pc    <= '0;
            br_cnt         <= '0;
            taken_cnt      <= '0;
        end else begin
            redirect_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (id_br_valid && !flush) begin
                        pc_r     <= id_pc;
                        imm_r    <= id_imm16;
                        cmp_ctrl <= id_br_cond;
                        if (!hazard_stall) begin
                            cmp_srcA <= id_rs_val;
                            cmp_srcB <= id_rt_val;
                        end
                    end
                end
                WAIT: begin
                    cmp_srcA <= id_rs_val;
                    cmp_srcB <= id_rt_val;
                end
                EVAL: begin
                    if (!flush) begin
                        taken_r        <= taken_now;
                        redirect_valid <= taken_now;
                        if (taken_now) begin
                            redirect_pc <= target;
                        end
                    end
                end
                DONE: begin
                    // The redirect was already committed, but a flush here
                    // still keeps this branch out of the statistics.
                    if (!flush) begin
                        if (br_cnt != CNT_MAX) begin
                            br_cnt <= br_cnt + CNT_W'(1);
                        end
                        if (taken_r && taken_cnt != CNT_MAX) begin
                            taken_cnt <= taken_cnt + CNT_W'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
